// File: rtl/seg_io_ctrl_pkg.sv
// Shared constants for the board I/O responder: register offsets and
// 7-segment glyph patterns (active-high, bit0=a .. bit6=g).
package seg_io_ctrl_pkg;

    localparam logic [3:0] OFF_DIGIT0 = 4'h0;
    localparam logic [3:0] OFF_DIGIT7 = 4'h7;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'h9;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [4:0] DIGIT_RST  = 5'h10;

    localparam logic [6:0] HEX_0 = 7'h3F;
    localparam logic [6:0] HEX_1 = 7'h06;
    localparam logic [6:0] HEX_2 = 7'h5B;
    localparam logic [6:0] HEX_3 = 7'h4F;
    localparam logic [6:0] HEX_4 = 7'h66;
    localparam logic [6:0] HEX_5 = 7'h6D;
    localparam logic [6:0] HEX_6 = 7'h7D;
    localparam logic [6:0] HEX_7 = 7'h07;
    localparam logic [6:0] HEX_8 = 7'h7F;
    localparam logic [6:0] HEX_9 = 7'h6F;
    localparam logic [6:0] HEX_A = 7'h77;
    localparam logic [6:0] HEX_B = 7'h7C;
    localparam logic [6:0] HEX_C = 7'h39;
    localparam logic [6:0] HEX_D = 7'h5E;
    localparam logic [6:0] HEX_E = 7'h79;
    localparam logic [6:0] HEX_F = 7'h71;

    function automatic logic [6:0] hex_pattern(input logic [3:0] value);
        logic [6:0] pat;
        case (value)
            4'h0: pat = HEX_0;
            4'h1: pat = HEX_1;
            4'h2: pat = HEX_2;
            4'h3: pat = HEX_3;
            4'h4: pat = HEX_4;
            4'h5: pat = HEX_5;
            4'h6: pat = HEX_6;
            4'h7: pat = HEX_7;
            4'h8: pat = HEX_8;
            4'h9: pat = HEX_9;
            4'hA: pat = HEX_A;
            4'hB: pat = HEX_B;
            4'hC: pat = HEX_C;
            4'hD: pat = HEX_D;
            4'hE: pat = HEX_E;
            default: pat = HEX_F;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex digit to active-low 7-segment pattern; blank forces all
// segments dark. Output register lives in the parent.
module seg7_hex_decoder
    import seg_io_ctrl_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : ~hex_pattern(value);
    end

endmodule

// File: rtl/seg_io_ctrl.sv
// Memory-mapped responder for the 6502 bus: eight hex displays, a global
// blank control and a debounced start button with a sticky rising-edge event.
module seg_io_ctrl
    import seg_io_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR       = 16'hFF00,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        sel,
    input  logic        start,
    output logic [6:0]  seg0,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3,
    output logic [6:0]  seg4,
    output logic [6:0]  seg5,
    output logic [6:0]  seg6,
    output logic [6:0]  seg7
);

    localparam int              CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             hit;
    logic [3:0]       off;
    logic             wr;
    logic [4:0]       digit [8];
    logic             ctrl_blank;
    logic             sync1, sync2;
    logic [CNT_W-1:0] db_cnt;
    logic             start_level;
    logic             start_event;
    logic             level_rise;
    logic             event_clr;
    logic [7:0]       rd_mux;
    logic [6:0]       dec_seg [8];
    logic [6:0]       seg_q   [8];
    logic             unused_wdata;

    assign hit          = (addr[15:4] == BASE_ADDR[15:4]);
    assign off          = addr[3:0];
    assign wr           = hit && we;
    assign unused_wdata = ^wdata[7:5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) digit[i] <= DIGIT_RST;
            ctrl_blank <= 1'b0;
        end else if (wr) begin
            if (!off[3])
                digit[off[2:0]] <= wdata[4:0];
            else if (off == OFF_CTRL)
                ctrl_blank <= wdata[0];
        end
    end

    // Debounce: count only while the synchronised input disagrees with the
    // accepted level; any return to agreement discards the partial count.
    assign level_rise = sync2 && !start_level && (db_cnt == CNT_TC);
    assign event_clr  = wr && (off == OFF_STATUS) && wdata[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            db_cnt      <= '0;
            start_level <= 1'b0;
            start_event <= 1'b0;
        end else begin
            sync1 <= start;
            sync2 <= sync1;
            if (sync2 == start_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CNT_TC) begin
                db_cnt      <= '0;
                start_level <= sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            // A new press takes priority over a same-cycle clear
            if (level_rise)
                start_event <= 1'b1;
            else if (event_clr)
                start_event <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        if (!off[3]) begin
            rd_mux = {3'b000, digit[off[2:0]]};
        end else begin
            case (off)
                OFF_STATUS: rd_mux = {6'b0, start_event, start_level};
                OFF_CTRL:   rd_mux = {7'b0, ctrl_blank};
                default:    rd_mux = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= 8'h00;
            sel   <= 1'b0;
        end else begin
            rdata <= hit ? rd_mux : 8'h00;
            sel   <= hit;
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_digit
        seg7_hex_decoder u_dec (
            .value (digit[g][3:0]),
            .blank (digit[g][4] | ctrl_blank),
            .seg   (dec_seg[g])
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                seg_q[g] <= SEG_BLANK;
            else
                seg_q[g] <= dec_seg[g];
        end
    end

    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];
    assign seg6 = seg_q[6];
    assign seg7 = seg_q[7];

endmodule

// File: tb/tb_seg_io_ctrl.sv
// Directed plus randomized bench for seg_io_ctrl against a register-level
// model of the display, control and start-button behaviour.
module tb_seg_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic        sel;
    logic        start;
    logic [6:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;

    int passed = 0;
    int total  = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [4:0] dig_m [8];
    logic       ctrl_m, lvl_m, ev_m;

    seg_io_ctrl dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .sel(sel), .start(start),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_exp(int i);
        return (ctrl_m || dig_m[i][4]) ? 7'h7F : ~hex_tab[dig_m[i][3:0]];
    endfunction

    function automatic logic [7:0] read_exp(logic [15:0] a);
        if (a[15:4] != 12'hFF0) return 8'h00;
        if (a[3:0] < 4'h8)      return {3'b000, dig_m[a[2:0]]};
        if (a[3:0] == 4'h8)     return {6'b0, ev_m, lvl_m};
        if (a[3:0] == 4'h9)     return {7'b0, ctrl_m};
        return 8'h00;
    endfunction

    function automatic logic [6:0] seg_get(int i);
        case (i)
            0: return seg0;
            1: return seg1;
            2: return seg2;
            3: return seg3;
            4: return seg4;
            5: return seg5;
            6: return seg6;
            default: return seg7;
        endcase
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_segs(string tag);
        for (int i = 0; i < 8; i++)
            check($sformatf("%s seg%0d", tag, i), {1'b0, seg_get(i)}, {1'b0, seg_exp(i)});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) dig_m[i] = 5'h10;
        ctrl_m = 1'b0;
        lvl_m  = 1'b0;
        ev_m   = 1'b0;
    endtask

    task automatic wr(logic [15:0] a, logic [7:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        cyc();
        we = 1'b0;
        if (a[15:4] == 12'hFF0) begin
            if (a[3:0] < 4'h8)                dig_m[a[2:0]] = d[4:0];
            else if (a[3:0] == 4'h9)          ctrl_m = d[0];
            else if (a[3:0] == 4'h8 && d[1])  ev_m = 1'b0;
        end
    endtask

    task automatic rd_check(string tag, logic [15:0] a);
        addr = a;
        we   = 1'b0;
        cyc();
        check({tag, " rdata"}, rdata, read_exp(a));
        check({tag, " sel"}, {7'b0, sel}, {7'b0, (a[15:4] == 12'hFF0)});
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  d;

        reset = 1'b1; addr = 16'h0000; wdata = 8'h00; we = 1'b0; start = 1'b0;
        model_reset();
        #2;
        check_segs("reset");
        check("reset rdata", rdata, 8'h00);
        check("reset sel", {7'b0, sel}, 8'h00);
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        // Digit writes and one-cycle display latency
        wr(16'hFF00, 8'h05);
        check("seg0 before update", {1'b0, seg0}, 8'h7F);
        wr(16'hFF07, 8'h0B);
        check("seg0 after write", {1'b0, seg0}, 8'h12);
        check("seg7 before update", {1'b0, seg7}, 8'h7F);
        cyc();
        check("seg7 after write", {1'b0, seg7}, 8'h03);
        rd_check("read digit7", 16'hFF07);
        check("digit7 value", rdata, 8'h0B);

        // Global blank
        wr(16'hFF09, 8'h01);
        cyc();
        check_segs("global blank");
        check("blank seg0", {1'b0, seg0}, 8'h7F);
        rd_check("digit0 under blank", 16'hFF00);
        rd_check("digit7 under blank", 16'hFF07);
        wr(16'hFF09, 8'h00);
        cyc();
        check_segs("unblank");
        check("unblank seg0", {1'b0, seg0}, 8'h12);

        // Random register traffic, including misses and reserved offsets
        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'hFE00 : 16'hFF00;
            a[3:0] = 4'($urandom_range(0, 15));
            d = 8'($urandom);
            wr(a, d);
            a = ($urandom_range(0, 4) == 0) ? 16'h1230 : 16'hFF00;
            a[3:0] = 4'($urandom_range(0, 15));
            rd_check($sformatf("rand%0d", n), a);
            check_segs($sformatf("rand%0d", n));
        end
        wr(16'hFF09, 8'h00);

        // Reserved and out-of-window accesses
        for (int o = 10; o < 16; o++) begin
            a = 16'hFF00 | 16'(o);
            rd_check($sformatf("reserved %0h", o), a);
            check($sformatf("reserved %0h zero", o), rdata, 8'h00);
        end
        rd_check("miss FE00", 16'hFE00);
        check("miss FE00 sel", {7'b0, sel}, 8'h00);
        wr(16'hFE00, 8'h03);
        wr(16'hFF0C, 8'hFF);
        wr(16'hFF0F, 8'h01);
        cyc();
        check_segs("after ignored writes");
        for (int i = 0; i < 10; i++) rd_check($sformatf("regs after ignored %0d", i), 16'hFF00 | 16'(i));

        // Short glitch on start is rejected
        addr = 16'hFF08;
        start = 1'b1;
        repeat (5) cyc();
        start = 1'b0;
        repeat (30) cyc();
        check("glitch status", rdata, 8'h00);

        // Held press: level changes on the 18th edge, visible in rdata one edge later
        start = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            cyc();
            if (k == 18) check("press edge 18", rdata, 8'h00);
            if (k == 19) check("press edge 19", rdata, 8'h03);
        end
        lvl_m = 1'b1; ev_m = 1'b1;
        repeat (981) cyc();
        rd_check("held status", 16'hFF08);

        // W1C: the same-cycle read returns the pre-write value
        addr = 16'hFF08; wdata = 8'h02; we = 1'b1;
        cyc();
        we = 1'b0;
        check("w1c pre-write read", rdata, 8'h03);
        ev_m = 1'b0;
        rd_check("after clear", 16'hFF08);

        start = 1'b0;
        repeat (20) cyc();
        lvl_m = 1'b0;
        rd_check("released", 16'hFF08);
        start = 1'b1;
        repeat (20) cyc();
        lvl_m = 1'b1; ev_m = 1'b1;
        rd_check("re-press", 16'hFF08);

        // Second press with W1C landing on the rising edge: set wins
        wr(16'hFF08, 8'h02);
        start = 1'b0;
        repeat (20) cyc();
        lvl_m = 1'b0;
        rd_check("before collide", 16'hFF08);
        start = 1'b1;
        repeat (17) cyc();
        addr = 16'hFF08; wdata = 8'h02; we = 1'b1;
        cyc();
        we = 1'b0;
        cyc();
        lvl_m = 1'b1; ev_m = 1'b1;
        rd_check("set beats clear", 16'hFF08);

        // Asynchronous reset mid-run with the button still held
        wr(16'hFF00, 8'h05);
        rd_check("pre-reset read", 16'hFF00);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_segs("async reset");
        check("async reset rdata", rdata, 8'h00);
        check("async reset sel", {7'b0, sel}, 8'h00);
        reset = 1'b0;
        rd_check("digit0 after reset", 16'hFF00);
        addr = 16'hFF08;
        repeat (25) cyc();
        lvl_m = 1'b1; ev_m = 1'b1;
        rd_check("requalify after reset", 16'hFF08);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
